// File: rtl/mem_master_pkg.sv
// Shared types and defaults for the byte-serialising memory word master.
package mem_master_pkg;

   typedef enum logic [1:0] {IDLE, STROBE, RELEASE, DONE} mm_state_t;

   localparam int unsigned ARCH_SIZE_DEFAULT      = 16;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

   function automatic int unsigned bytes_of(input int unsigned arch_size);
      return arch_size / 8;
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait counter; expired rises once TIMEOUT_CYCLES enabled cycles have elapsed since clear.
module mem_timeout_counter
   import mem_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;

   // Expiry is judged at the edge that closes the TIMEOUT_CYCLES-th waiting cycle.
   assign expired = (count_q == LIMIT);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/mem_word_master.sv
// Word load/store master that walks a word through a byte-wide read/write/ready
// responder, LSB first, with return-to-zero handshaking and a per-phase timeout.
module mem_word_master
   import mem_master_pkg::*;
#(
   parameter int unsigned ARCH_SIZE      = ARCH_SIZE_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   input  logic                 req_write,
   input  logic [ARCH_SIZE-1:0] req_addr,
   input  logic [ARCH_SIZE-1:0] req_wdata,
   output logic                 req_ready,
   output logic                 rsp_valid,
   output logic [ARCH_SIZE-1:0] rsp_rdata,
   output logic                 rsp_error,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [ARCH_SIZE-1:0] mem_address,
   output logic [7:0]           mem_write_value,
   input  logic [7:0]           mem_read_value,
   input  logic                 mem_ready
);

   localparam int unsigned BYTES = bytes_of(ARCH_SIZE);
   localparam int unsigned IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

   mm_state_t              state_q, state_d;
   logic [IDXW-1:0]        idx_q, idx_d, idx_next;
   logic                   write_q, write_d;
   logic                   abort_q, abort_d;
   logic [ARCH_SIZE-1:0]   base_q, base_d;
   logic [ARCH_SIZE-1:0]   wdata_q, wdata_d;
   logic [ARCH_SIZE-1:0]   rdata_q, rdata_d;
   logic                   req_ready_q, req_ready_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_error_q, rsp_error_d;
   logic [ARCH_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                   mem_read_q, mem_read_d;
   logic                   mem_write_q, mem_write_d;
   logic [ARCH_SIZE-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]             mem_wval_q, mem_wval_d;
   logic                   tmr_clear, tmr_enable, tmr_expired;

   assign idx_next   = idx_q + IDXW'(1);
   assign tmr_clear  = (state_d != state_q);
   assign tmr_enable = (state_q == STROBE) || (state_q == RELEASE);

   mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      write_d     = write_q;
      abort_d     = abort_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = rsp_error_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wval_d  = mem_wval_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d     = req_write;
               base_d      = req_addr;
               wdata_d     = req_wdata;
               rdata_d     = '0;
               idx_d       = '0;
               abort_d     = 1'b0;
               mem_read_d  = !req_write;
               mem_write_d = req_write;
               mem_addr_d  = req_addr;
               mem_wval_d  = req_wdata[7:0];
               state_d     = STROBE;
            end
         end
         STROBE: begin
            // A ready already high on entry counts: combinational responders rely on it.
            if (mem_ready) begin
               if (!write_q) rdata_d[{idx_q, 3'b000} +: 8] = mem_read_value;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = RELEASE;
            end else if (tmr_expired) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               abort_d     = 1'b1;
               state_d     = RELEASE;
            end
         end
         RELEASE: begin
            if (!mem_ready) begin
               if (abort_q || (idx_q == LAST_IDX)) begin
                  rsp_valid_d = 1'b1;
                  rsp_error_d = abort_q;
                  if (!write_q) rsp_rdata_d = rdata_q;
                  state_d     = DONE;
               end else begin
                  idx_d       = idx_next;
                  mem_read_d  = !write_q;
                  mem_write_d = write_q;
                  mem_addr_d  = base_q + ARCH_SIZE'(idx_next);
                  mem_wval_d  = wdata_q[{idx_next, 3'b000} +: 8];
                  state_d     = STROBE;
               end
            end else if (tmr_expired) begin
               abort_d     = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               if (!write_q) rsp_rdata_d = rdata_q;
               state_d     = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         write_q     <= 1'b0;
         abort_q     <= 1'b0;
         base_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wval_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         write_q     <= write_d;
         abort_q     <= abort_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wval_q  <= mem_wval_d;
      end
   end

   assign req_ready       = req_ready_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_error       = rsp_error_q;
   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_address     = mem_addr_q;
   assign mem_write_value = mem_wval_q;

endmodule

// File: tb/tb_mem_word_master.sv
// Bench for mem_word_master: byte responder with programmable ready/release delays
// and a byte-array reference memory updated from plain word arithmetic.
module tb_mem_word_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_error;
   logic [15:0] rsp_rdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_address;
   logic [7:0]  mem_write_value, mem_read_value;
   logic        mem_ready;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_word_master #(.ARCH_SIZE(16), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_value(mem_write_value), .mem_read_value(mem_read_value), .mem_ready(mem_ready)
   );

   // Responder: ready after rdy_delay strobe cycles, held rel_delay cycles past the strobe.
   bit [7:0]    mem [0:65535];
   bit [7:0]    model_mem [0:65535];
   int unsigned rdy_delay = 0, rel_delay = 0, hi_cnt = 0, rel_cnt = 0;
   bit          never_ready = 0;
   int          wr_cnt = 0;

   assign mem_ready = !never_ready &&
                      (((mem_read || mem_write) && hi_cnt >= rdy_delay) || rel_cnt != 0);
   assign mem_read_value = mem[mem_address];

   always @(posedge clk) begin
      if (mem_write && mem_ready) begin
         mem[mem_address] <= mem_write_value;
         wr_cnt <= wr_cnt + 1;
      end
      hi_cnt <= (mem_read || mem_write) ? hi_cnt + 1 : 0;
      if ((mem_read || mem_write) && mem_ready) rel_cnt <= rel_delay;
      else if (rel_cnt != 0)                    rel_cnt <= rel_cnt - 1;
   end

   // Protocol monitor: no overlapping strobes, no strobe while ready lingers high.
   int both_cnt = 0, rtz_cnt = 0;
   bit prev_strobe = 0, prev_ready = 0;
   always @(negedge clk) begin
      if (mem_read && mem_write) both_cnt = both_cnt + 1;
      if ((mem_read || mem_write) && !prev_strobe && prev_ready) rtz_cnt = rtz_cnt + 1;
      prev_strobe = mem_read || mem_write;
      prev_ready  = mem_ready;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] model_word(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {model_mem[a1], model_mem[a]};
   endfunction

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {mem[a1], mem[a]};
   endfunction

   task automatic model_store(input logic [15:0] a, input logic [15:0] d);
      logic [15:0] a1;
      a1 = a + 16'd1;
      model_mem[a]  = d[7:0];
      model_mem[a1] = d[15:8];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transfer; latency counts cycles after the accepting edge.
   task automatic txn(input string tag, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic er, output int lat, output int strobe_cyc);
      int guard;
      guard = 0;
      while (!req_ready && guard < 100) begin step(); guard++; end
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      step();
      req_valid = 1'b0;
      lat = 1; strobe_cyc = 0;
      while (!rsp_valid && lat < 200) begin
         if (mem_read || mem_write) strobe_cyc++;
         step();
         lat++;
      end
      check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
      rd = rsp_rdata; er = rsp_error;
      step();
      check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
   endtask

   logic [15:0] rd, a, d, addr_c, data_c;
   logic        er;
   int          lat, sc, w0, g, cnt;
   bit          wr;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      step(); step();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_error", 32'(rsp_error), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_mem_addr", 32'(mem_address), 32'd0);
      check("rst_mem_wval", 32'(mem_write_value), 32'd0);
      reset = 1'b0;
      step();

      // Store 0x1234 at 0x0010 with an instant responder.
      rdy_delay = 0; rel_delay = 0;
      txn("t1", 1'b1, 16'h0010, 16'h1234, rd, er, lat, sc);
      model_store(16'h0010, 16'h1234);
      check("t1_latency", 32'(lat), 32'd5);
      check("t1_err", 32'(er), 32'd0);
      check("t1_mem10", 32'(mem[16'h0010]), 32'h34);
      check("t1_mem11", 32'(mem[16'h0011]), 32'h12);

      // Load it back through a slow responder that also holds ready after the strobe.
      rdy_delay = 3; rel_delay = 2;
      txn("t2", 1'b0, 16'h0010, 16'h0000, rd, er, lat, sc);
      check("t2_rdata", 32'(rd), 32'h1234);
      check("t2_err", 32'(er), 32'd0);

      // Address wrap across the top of memory.
      rdy_delay = 1; rel_delay = 1;
      txn("t3", 1'b1, 16'hFFFF, 16'hABCD, rd, er, lat, sc);
      model_store(16'hFFFF, 16'hABCD);
      check("t3_memFFFF", 32'(mem[16'hFFFF]), 32'hCD);
      check("t3_mem0000", 32'(mem[16'h0000]), 32'hAB);

      // Responder never answers: strobe held 8 cycles, then an error response.
      never_ready = 1'b1;
      txn("t4", 1'b0, 16'h0010, 16'h0000, rd, er, lat, sc);
      never_ready = 1'b0;
      check("t4_strobe_cycles", 32'(sc), 32'd8);
      check("t4_err", 32'(er), 32'd1);
      check("t4_rdata", 32'(rd), 32'd0);

      // Reset while byte 0 of a store is strobing.
      rdy_delay = 20; rel_delay = 0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h2000; req_wdata = 16'h7777;
      step();
      req_valid = 1'b0;
      check("t5_write_strobe", 32'(mem_write), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_strobes_dropped", {30'd0, mem_read, mem_write}, 32'd0);
      check("t5_req_ready", 32'(req_ready), 32'd1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin step(); if (rsp_valid) cnt++; end
      check("t5_no_rsp", 32'(cnt), 32'd0);
      check("t5_byte1_untouched", 32'(mem[16'h2001]), 32'(model_mem[16'h2001]));
      check("t5_byte0_untouched", 32'(mem[16'h2000]), 32'(model_mem[16'h2000]));

      // Request held through a busy transfer with changing fields.
      rdy_delay = 1; rel_delay = 0;
      w0 = wr_cnt;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h4000; req_wdata = 16'h5A5A;
      step();
      g = 0;
      while (!rsp_valid && g < 100) begin
         req_addr = 16'h8000 | 16'($urandom_range(0, 255)); req_wdata = 16'($urandom);
         step(); g++;
      end
      check("t6_first_rsp", 32'(rsp_valid), 32'd1);
      addr_c = 16'h6000; data_c = 16'hC3E1;
      req_addr = addr_c; req_wdata = data_c;
      step();
      check("t6_ready_after_rsp", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      check("t6_second_addr", 32'(mem_address), 32'(addr_c));
      g = 0;
      while (!rsp_valid && g < 100) begin step(); g++; end
      check("t6_second_rsp", 32'(rsp_valid), 32'd1);
      step();
      model_store(16'h4000, 16'h5A5A);
      model_store(addr_c, data_c);
      check("t6_word_first", 32'(mem_word(16'h4000)), 32'(model_word(16'h4000)));
      check("t6_word_second", 32'(mem_word(addr_c)), 32'(model_word(addr_c)));
      check("t6_write_count", 32'(wr_cnt - w0), 32'd4);

      // Random loads and stores against the reference memory.
      for (int i = 0; i < 24; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = (i % 3 == 0) ? 16'h0010 + 16'($urandom_range(0, 3)) : 16'($urandom);
         d  = 16'($urandom);
         rdy_delay = $urandom_range(0, 4);
         rel_delay = $urandom_range(0, 2);
         txn($sformatf("rnd%0d", i), wr, a, d, rd, er, lat, sc);
         check($sformatf("rnd%0d_err", i), 32'(er), 32'd0);
         if (wr) begin
            model_store(a, d);
            check($sformatf("rnd%0d_store", i), 32'(mem_word(a)), 32'(model_word(a)));
         end else begin
            check($sformatf("rnd%0d_load", i), 32'(rd), 32'(model_word(a)));
         end
      end

      check("proto_no_overlap", 32'(both_cnt), 32'd0);
      check("proto_return_to_zero", 32'(rtz_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
